// File: rtl/spawn_picker_pkg.sv
// Shared state encoding and screen geometry for the spawn picker.
// Imported by the picker top and its testbench.
package spawn_picker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Gap counter width; a gap of one still needs a 1-bit counter.
  function automatic int cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/spawn_picker_if.sv
// Request/result handshake between placement logic and spawn picker.
// master: requester (req, ack); slave: picker (busy, valid, x, y).
interface spawn_picker_if #(
  parameter int XW = 8,
  parameter int YW = 7
);
  logic          req;
  logic          ack;
  logic          busy;
  logic          valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  modport master (
    output req, ack,
    input  busy, valid, x, y
  );

  modport slave (
    input  req, ack,
    output busy, valid, x, y
  );
endinterface

// File: rtl/spawn_picker_range_reduce.sv
// One step of range reduction: flags val < MAX and gives val - MAX
// otherwise. Ports: val in, in_range / nxt out. Purely combinational.
module range_reduce #(
  parameter int W   = 8,
  parameter int MAX = 160
) (
  input  logic [W-1:0] val,
  output logic         in_range,
  output logic [W-1:0] nxt
);

  // One extra bit so MAX == 2^W is representable.
  localparam logic [W:0] LIM = (W+1)'(MAX);

  assign in_range = {1'b0, val} < LIM;
  assign nxt = in_range ? val : val - LIM[W-1:0];

endmodule

// File: rtl/spawn_picker.sv
// Turns two time-separated LFSR samples into a bounded spawn (x, y).
// Ports: clock, resetn, rnd[12:0] LFSR word, bus (slave handshake).
module spawn_picker
  import spawn_picker_pkg::*;
#(
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int GAP   = 13
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [12:0] rnd,
  spawn_picker_if.slave bus
);

  localparam int CW = cnt_w(GAP);
  localparam logic [CW-1:0] CNT_LAST = CW'(GAP - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [XW-1:0] x_raw;
  logic [XW-1:0] x_nx;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_raw;
  logic [YW-1:0] y_nx;
  logic [YW-1:0] y_q;
  logic          x_in;
  logic          y_in;
  logic          gap_end;

  range_reduce #(.W(XW), .MAX(X_MAX)) u_rx (
    .val      (x_raw),
    .in_range (x_in),
    .nxt      (x_nx)
  );

  range_reduce #(.W(YW), .MAX(Y_MAX)) u_ry (
    .val      (y_raw),
    .in_range (y_in),
    .nxt      (y_nx)
  );

  assign gap_end = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (bus.req) state_n = ST_WAIT;
      ST_WAIT:   if (gap_end) state_n = ST_REDUCE;
      ST_REDUCE: if (x_in && y_in) state_n = ST_DONE;
      ST_DONE:   if (bus.ack) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      x_raw <= '0;
      y_raw <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req) begin
            x_raw <= rnd[XW-1:0];
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CW'(1);
          if (gap_end) y_raw <= rnd[YW-1:0];
        end
        ST_REDUCE: begin
          // In-range values pass through unchanged.
          x_raw <= x_nx;
          y_raw <= y_nx;
          if (x_in && y_in) begin
            x_q <= x_raw;
            y_q <= y_raw;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.valid = (state == ST_DONE);
  assign bus.x     = x_q;
  assign bus.y     = y_q;

endmodule

// File: tb/tb_spawn_picker.sv
// Directed bench for spawn_picker: reduction, handshake, reset,
// plus an LFSR-driven soak of back-to-back requests.
module tb_spawn_picker;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [12:0] rnd_drv = '0;
  logic [12:0] lfsr = 13'h1ACE;
  logic        use_lfsr = 1'b0;
  logic [12:0] rnd;
  int          vectors = 0;
  int          miscompares = 0;

  spawn_picker_if #(.XW(8), .YW(7)) bus ();

  assign rnd = use_lfsr ? lfsr : rnd_drv;

  spawn_picker dut (
    .clock  (clock),
    .resetn (resetn),
    .rnd    (rnd),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    lfsr <= {lfsr[11:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ack_out(input string tag);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk({tag, "_vdrop"}, 16'(bus.valid), 16'd0);
  endtask

  task automatic run_txn(input logic [7:0] xr, input logic [6:0] yr,
                         input logic [7:0] ex, input logic [6:0] ey,
                         input int lat, input bit hold_req,
                         input bit early_ack, input string tag);
    int n;
    rnd_drv = {5'd0, xr};
    bus.req = 1'b1;
    step();
    n = 0;
    if (!hold_req) bus.req = 1'b0;
    chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
    for (int i = 1; i <= 13; i++) begin
      if (i == 13) rnd_drv = {6'($urandom), yr};
      else         rnd_drv = 13'($urandom);
      if (early_ack) bus.ack = (i >= 3 && i <= 5);
      step();
      n = i;
    end
    bus.ack = 1'b0;
    rnd_drv = 13'($urandom);
    while (!bus.valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(lat));
    chk({tag, "_x"}, 16'(bus.x), 16'(ex));
    chk({tag, "_y"}, 16'(bus.y), 16'(ey));
  endtask

  initial begin
    logic [7:0] lastx;
    bit         all_same;
    bus.req = 1'b1;
    bus.ack = 1'b0;
    rnd_drv = 13'h00AB;

    // Reset held with req asserted.
    repeat (3) step();
    chk("rst_x", 16'(bus.x), 16'd0);
    chk("rst_y", 16'(bus.y), 16'd0);
    chk("rst_valid", 16'(bus.valid), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    resetn = 1'b1;
    step();
    chk("rel_busy", 16'(bus.busy), 16'd1);
    resetn = 1'b0;
    #1;
    chk("rst2_busy", 16'(bus.busy), 16'd0);
    bus.req = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // One subtraction on x; hold until ack.
    run_txn(8'd171, 7'd90, 8'd11, 7'd90, 15, 1'b0, 1'b0, "one_sub");
    repeat (3) begin
      step();
      chk("hold_valid", 16'(bus.valid), 16'd1);
      chk("hold_x", 16'(bus.x), 16'd11);
      chk("hold_y", 16'(bus.y), 16'd90);
    end
    ack_out("one_sub");
    chk("one_sub_idle", 16'(bus.busy), 16'd0);

    // Only y reduced; ack pulsed during WAIT is ignored.
    run_txn(8'd100, 7'd127, 8'd100, 7'd7, 15, 1'b0, 1'b1, "y_only");
    ack_out("y_only");

    // Bound edges.
    run_txn(8'd159, 7'd119, 8'd159, 7'd119, 14, 1'b0, 1'b0, "edge_in");
    ack_out("edge_in");
    run_txn(8'd160, 7'd120, 8'd0, 7'd0, 15, 1'b0, 1'b0, "edge_eq");
    ack_out("edge_eq");

    // req held through a transaction, then req+ack together in DONE.
    run_txn(8'd23, 7'd45, 8'd23, 7'd45, 14, 1'b1, 1'b0, "req_hold");
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk("reqack_valid", 16'(bus.valid), 16'd0);
    chk("reqack_busy", 16'(bus.busy), 16'd0);
    run_txn(8'd200, 7'd100, 8'd40, 7'd100, 15, 1'b1, 1'b0, "recap");
    bus.req = 1'b0;
    ack_out("recap");

    // Asynchronous reset in the middle of WAIT.
    rnd_drv = 13'd50;
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    repeat (5) step();
    chk("mid_busy_pre", 16'(bus.busy), 16'd1);
    resetn = 1'b0;
    #1;
    chk("mid_valid", 16'(bus.valid), 16'd0);
    chk("mid_busy", 16'(bus.busy), 16'd0);
    chk("mid_x", 16'(bus.x), 16'd0);
    #2;
    resetn = 1'b1;
    step();
    chk("mid_idle", 16'(bus.busy), 16'd0);
    run_txn(8'd5, 7'd6, 8'd5, 7'd6, 14, 1'b0, 1'b0, "post_rst");
    ack_out("post_rst");

    // Real LFSR, back-to-back requests.
    use_lfsr = 1'b1;
    all_same = 1'b1;
    lastx = '0;
    for (int r = 0; r < 200; r++) begin
      int n;
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      n = 0;
      while (!bus.valid && n < 20) begin
        step();
        n++;
      end
      chk("int_lat", 16'(n >= 14 && n <= 15), 16'd1);
      chk("int_x_lt", 16'(bus.x < 8'd160), 16'd1);
      chk("int_y_lt", 16'(bus.y < 7'd120), 16'd1);
      if (r > 0 && bus.x != lastx) all_same = 1'b0;
      lastx = bus.x;
      ack_out("int");
    end
    chk("int_x_varies", 16'(all_same), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
